// File: rtl/mux_sel_if.sv
// Handshake bundle between the mux select scheduler and its environment.
// The scheduler uses the slave view; the surrounding logic (or a bench) uses the master view.
interface mux_sel_if #(
    parameter int unsigned CNT_W = 27
);
    logic             en;
    logic             btn_req;
    logic             hold;
    logic             sel;
    logic             sel_chg;
    logic             btn_pending;
    logic [CNT_W-1:0] slot_cnt;

    modport master (
        output en, btn_req, hold,
        input  sel, sel_chg, btn_pending, slot_cnt
    );

    modport slave (
        input  en, btn_req, hold,
        output sel, sel_chg, btn_pending, slot_cnt
    );
endinterface

// File: rtl/mux_sel_scheduler.sv
// Time-sliced select for the switch/button source mux, with hold, run enable and latched button requests.
// Optional early switch-to-button preemption is compiled in when BTN_PREEMPT_EN is defined.
module mux_sel_scheduler #(
    parameter int unsigned DWELL_CYCLES     = 100000000,
    parameter int unsigned MIN_DWELL_CYCLES = 25000000,
    parameter int unsigned CNT_W            = 27
) (
    input  logic     clk,
    input  logic     rst,
    mux_sel_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);

    // Elaboration-time guard on the parameter set.
    if (DWELL_CYCLES < 2 || MIN_DWELL_CYCLES < 1 || MIN_DWELL_CYCLES >= DWELL_CYCLES) begin : g_bad_params
        $error("mux_sel_scheduler: illegal DWELL_CYCLES/MIN_DWELL_CYCLES");
    end

    typedef enum logic {
        SW_SLOT  = 1'b0,
        BTN_SLOT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pend;
    logic             pend_nxt;
    logic             sel_q;
    logic             chg_q;
    logic             expire_c;
    logic             preempt_c;
    logic             take_c;

    // Next-state, counter and request-latch decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        preempt_c = 1'b0;

        expire_c = bus.en && (cnt == CNT_MAX);
`ifdef BTN_PREEMPT_EN
        preempt_c = bus.en && (state == SW_SLOT) && pend
                    && (cnt >= CNT_W'(MIN_DWELL_CYCLES - 1));
`endif
        // Expiry and preemption in one cycle still make a single transition.
        take_c = (expire_c || preempt_c) && !bus.hold;

        if (take_c) begin
            state_nxt = (state == SW_SLOT) ? BTN_SLOT : SW_SLOT;
            cnt_nxt   = '0;
        end else if (bus.en && (cnt != CNT_MAX)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end

        // Entering the button slot services any request, including one arriving that cycle.
        if (take_c && (state_nxt == BTN_SLOT)) begin
            pend_nxt = 1'b0;
        end else if (bus.btn_req) begin
            pend_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SW_SLOT;
            cnt   <= '0;
            pend  <= 1'b0;
            sel_q <= 1'b0;
            chg_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            sel_q <= (state_nxt == BTN_SLOT);
            chg_q <= take_c;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.sel_chg     = chg_q;
    assign bus.btn_pending = pend;
    assign bus.slot_cnt    = cnt;
endmodule

// File: doc/mux_sel_scheduler.md
Name: mux_sel_scheduler

Overview:
- Drives the select line of the 2:1 source mux that chooses between switch-state (sel=0) and button-state (sel=1) data feeding the elevator controller.
- Time-slices the mux with a fixed dwell period (nominally 2 s), honours a downstream hold, and latches button requests so none are lost between slots.
- Sits between the board input conditioning (debounced switches and buttons) and the mux.
- Emits a one-cycle strobe on every select change so downstream logic can resample.

Parameters:
- DWELL_CYCLES, 100000000, slot length in clk cycles (2 s at 50 MHz); must be >= 2.
- MIN_DWELL_CYCLES, 25000000, minimum time in the switch slot before a button preemption may occur; must be >= 1 and < DWELL_CYCLES.
- CNT_W, 27, dwell counter width; must hold DWELL_CYCLES-1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- en  input  1  scheduler run enable; low freezes the counter and state
- btn_req  input  1  single-cycle pulse, debounced button press
- hold  input  1  downstream busy; blocks any select change while high
- sel  output  1  mux select: 0 = switch source, 1 = button source
- sel_chg  output  1  one-cycle pulse in the cycle sel takes its new value
- btn_pending  output  1  latched unserviced button request
- slot_cnt  output  CNT_W  current dwell count, for debug and display

Behaviour:
- Reset:
  - rst is sampled on the rising clk edge only.
  - Reset state: SW_SLOT, sel=0, sel_chg=0, btn_pending=0, slot_cnt=0.
  - Reset overrides every other input in the same cycle, including a mid-slot or mid-hold reset.
- States:
  - SW_SLOT: sel=0.
  - BTN_SLOT: sel=1.
  - sel is a registered decode of the state.
- Counter:
  - When en=1, slot_cnt increments each cycle.
  - It saturates at DWELL_CYCLES-1 and never wraps past it.
  - It clears to 0 in the cycle a transition is taken.
  - When en=0, slot_cnt holds.
- Expiry:
  - Expiry occurs when slot_cnt==DWELL_CYCLES-1 and en=1.
  - On expiry with hold=0, the state toggles. The new sel and sel_chg=1 appear on the next edge, i.e. sel changes exactly DWELL_CYCLES cycles after the previous change when there is no hold.
  - On expiry with hold=1, the state is kept and the counter stays saturated. The toggle occurs on the first cycle with hold=0 (latency 1 cycle after hold falls).
- btn_pending:
  - Set on any cycle with btn_req=1, regardless of en or state.
  - Cleared on entry to BTN_SLOT.
  - If btn_req=1 in the same cycle as entry to BTN_SLOT, the request counts as serviced and btn_pending ends at 0.
  - btn_req while already in BTN_SLOT sets btn_pending; it is served in the next BTN_SLOT.
- sel_chg:
  - High for exactly one cycle per transition.
  - Never high during reset or while en=0.
- en:
  - en=0 blocks all transitions, including preemption.
  - btn_pending still latches while en=0.
- Simultaneous expiry and preemption in the same cycle yield a single transition and a single sel_chg pulse.

Optional Feature:
- Macro: BTN_PREEMPT_EN.
- Defined:
  - In SW_SLOT with btn_pending=1, slot_cnt >= MIN_DWELL_CYCLES-1, en=1 and hold=0, move to BTN_SLOT early.
  - The counter clears and sel_chg pulses.
  - BTN_SLOT always runs the full DWELL_CYCLES; there is no preemption back to SW_SLOT.
- Undefined:
  - Strict time-slicing only.
  - btn_pending is tracked and cleared identically but never causes an early transition.
  - MIN_DWELL_CYCLES is unused.

Test Plan:
Benches use DWELL_CYCLES=8, MIN_DWELL_CYCLES=3, CNT_W=4.
- Reset, then en=1, hold=0, no buttons, 40 cycles.
  - Expect: sel toggles every 8 cycles (0,1,0,1,0) with a 1-cycle sel_chg at each toggle. slot_cnt runs 0..7 and clears.
- Hold at expiry: hold=1 from cycle 6 to cycle 12 of an SW_SLOT.
  - Expect: slot_cnt saturates at 7 and sel stays 0.
  - Expect: sel=1 with sel_chg one cycle after hold falls.
- btn_req pulse at cycle 1 of SW_SLOT.
  - With BTN_PREEMPT_EN: btn_pending=1 from cycle 2; transition when slot_cnt reaches 2; sel=1 at cycle 3 and btn_pending clears.
  - Without BTN_PREEMPT_EN: sel=1 only at cycle 8.
- btn_req coincident with the BTN_SLOT entry edge.
  - Expect: btn_pending stays 0.
- btn_req during BTN_SLOT.
  - Expect: btn_pending=1 through the following SW_SLOT and cleared at the next BTN_SLOT entry.
- en=0 for 10 cycles mid-slot (slot_cnt=4), with a btn_req pulse during that window.
  - Expect: slot_cnt frozen at 4, no sel_chg, btn_pending=1.
  - After en returns: normal resumption.
- Assert rst mid-hold in BTN_SLOT.
  - Expect: next edge gives sel=0, slot_cnt=0, btn_pending=0, sel_chg=0.
